div_query_client: RTL and testbench

DIV_QUERY_CLIENT -- requirements
Module: div_query_client

---
 rtl/div_client_pkg.sv | 39 +++
 rtl/dec_ascii_conv.sv | 69 ++++++
 rtl/div_query_client.sv | 177 +++++++++++++++++
 tb/tb_div_query_client.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_client_pkg.sv
// Shared types, ASCII constants and small helpers for the divide-query client.
package div_client_pkg;

  typedef enum logic [3:0] {
    IDLE, CONV_A, WAIT_P1, SEND_A, WAIT_P2, CONV_B,
    SEND_B, WAIT_0, WAIT_X, HEX, WAIT_DOT, FIN
  } state_t;

  typedef enum logic [1:0] {TX_PRESENT, TX_RISE, TX_FALL, TX_ECHO} tx_phase_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;

  function automatic logic [15:0] pow10(input logic [2:0] place);
    case (place)
      3'd0:    return 16'd10000;
      3'd1:    return 16'd1000;
      3'd2:    return 16'd100;
      3'd3:    return 16'd10;
      default: return 16'd1;
    endcase
  endfunction

  // {valid, nibble}; accepts 0-9, A-F, a-f
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'd0;
  endfunction

endpackage

// File: rtl/dec_ascii_conv.sv
// Binary-to-decimal ASCII converter by repeated subtraction; emits digits + CR
// into o_buf and pulses o_ready when the string is complete.
module dec_ascii_conv
  import div_client_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [15:0]     i_value,
  output logic            o_ready,
  output logic [5:0][7:0] o_buf,
  output logic [2:0]      o_len
);

  logic            r_busy;
  logic            r_ready;
  logic [15:0]     r_rem;
  logic [2:0]      r_place;
  logic [3:0]      r_dig;
  logic [5:0][7:0] r_buf;
  logic [2:0]      r_len;
  logic [15:0]     w_pow;

  assign w_pow   = pow10(r_place);
  assign o_ready = r_ready;
  assign o_buf   = r_buf;
  assign o_len   = r_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_rem   <= '0;
      r_place <= '0;
      r_dig   <= '0;
      r_buf   <= '0;
      r_len   <= '0;
    end else begin
      r_ready <= 1'b0;
      if (i_start) begin
        r_busy  <= 1'b1;
        r_rem   <= i_value;
        r_place <= '0;
        r_dig   <= '0;
        r_len   <= '0;
      end else if (r_busy) begin
        if (r_place == 3'd4) begin
          // units digit is always emitted so that 0 yields "0"
          r_buf[r_len]        <= ASCII_ZERO + {4'd0, r_rem[3:0]};
          r_buf[r_len + 3'd1] <= ASCII_CR;
          r_len   <= r_len + 3'd2;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end else if (r_rem >= w_pow) begin
          r_rem <= r_rem - w_pow;
          r_dig <= r_dig + 4'd1;
        end else begin
          if (r_dig != 4'd0 || r_len != 3'd0) begin
            r_buf[r_len] <= ASCII_ZERO + {4'd0, r_dig};
            r_len        <= r_len + 3'd1;
          end
          r_dig   <= '0;
          r_place <= r_place + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/div_query_client.sv
// UART client: sends "a\r" and "b\r" after ": " prompts, parses "0xHHHH." reply.
// Optional echo verification of sent bytes under DIV_CLIENT_ECHO_CHECK_EN.
module div_query_client
  import div_client_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  input  logic        is_transmitting,
  input  logic [7:0]  rx_byte,
  input  logic        received
);

  state_t          r_state, w_next;
  tx_phase_t       r_phase;
  logic [2:0]      r_idx;
  logic [15:0]     r_b, r_shift, r_result;
  logic [1:0]      r_hexcnt;
  logic            r_colon, r_err;
  logic [31:0]     r_tmo;

  logic            w_err, w_send, w_last, w_prompt, w_send_done;
  logic            w_tmo_state, w_tmo_hit, w_conv_start, w_conv_ready;
  logic [15:0]     w_conv_val;
  logic [5:0][7:0] w_buf;
  logic [2:0]      w_len;
  logic [4:0]      w_hex;
`ifdef DIV_CLIENT_ECHO_CHECK_EN
  logic [2:0]      r_echo_idx;
  logic            w_echo_bad;
`endif

  assign w_send       = (r_state == SEND_A) || (r_state == SEND_B);
  assign w_last       = (r_idx == w_len - 3'd1);
  assign w_prompt     = received && r_colon && (rx_byte == ASCII_SPACE);
  assign w_hex        = hex_decode(rx_byte);
  assign w_conv_start = ((r_state == IDLE) && start) || ((r_state == WAIT_P2) && w_prompt);
  assign w_conv_val   = (r_state == IDLE) ? op_a : r_b;

`ifdef DIV_CLIENT_ECHO_CHECK_EN
  assign w_send_done = (r_phase == TX_ECHO) && (r_echo_idx == w_len);
  assign w_echo_bad  = w_send && received && (r_echo_idx < w_len) &&
                       (rx_byte != w_buf[r_echo_idx]);
  assign w_tmo_state = (r_state inside {WAIT_P1, WAIT_P2, WAIT_0, WAIT_X, HEX, WAIT_DOT}) ||
                       (w_send && r_phase == TX_ECHO);
`else
  assign w_send_done = (r_phase == TX_FALL) && !is_transmitting && w_last;
  assign w_tmo_state = r_state inside {WAIT_P1, WAIT_P2, WAIT_0, WAIT_X, HEX, WAIT_DOT};
`endif
  // a byte arriving in the expiry cycle takes precedence over the timeout
  assign w_tmo_hit = w_tmo_state && !received && (r_tmo >= 32'(TIMEOUT_CYCLES));

  dec_ascii_conv u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_conv_start),
    .i_value (w_conv_val),
    .o_ready (w_conv_ready),
    .o_buf   (w_buf),
    .o_len   (w_len)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      IDLE:     if (start) w_next = CONV_A;
      CONV_A:   if (w_conv_ready) w_next = WAIT_P1;
      WAIT_P1:  if (w_prompt) w_next = SEND_A;
      SEND_A:   if (w_send_done) w_next = WAIT_P2;
      WAIT_P2:  if (w_prompt) w_next = CONV_B;
      CONV_B:   if (w_conv_ready) w_next = SEND_B;
      SEND_B:   if (w_send_done) w_next = WAIT_0;
      WAIT_0:   if (received && rx_byte == ASCII_ZERO) w_next = WAIT_X;
      WAIT_X:   if (received) w_next = (rx_byte == ASCII_X)    ? HEX    :
                                       (rx_byte == ASCII_ZERO) ? WAIT_X : WAIT_0;
      HEX:      if (received) begin
                  if (!w_hex[4])               w_err  = 1'b1;
                  else if (r_hexcnt == 2'd3)   w_next = WAIT_DOT;
                end
      WAIT_DOT: if (received) begin
                  if (rx_byte == ASCII_DOT) w_next = FIN;
                  else                      w_err  = 1'b1;
                end
      FIN:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_tmo_hit) w_err = 1'b1;
`ifdef DIV_CLIENT_ECHO_CHECK_EN
    if (w_echo_bad) w_err = 1'b1;
`endif
    if (w_err) w_next = IDLE;
  end

  always_comb begin
    busy     = (r_state != IDLE);
    done     = (r_state == FIN);
    err      = r_err;
    result   = r_result;
    transmit = w_send && (r_phase == TX_PRESENT);
    tx_byte  = w_send ? w_buf[r_idx] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= TX_PRESENT;
      r_idx    <= '0;
      r_b      <= '0;
      r_shift  <= '0;
      r_result <= '0;
      r_hexcnt <= '0;
      r_colon  <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= '0;
    end else begin
      r_err <= w_err;
      if ((r_state == IDLE) && start) r_b <= op_b;

      if (received || (r_state != w_next) || !w_tmo_state) r_tmo <= '0;
      else                                                  r_tmo <= r_tmo + 32'd1;

      if (r_state != w_next) r_colon <= 1'b0;
      else if (received)     r_colon <= (rx_byte == ASCII_COLON);

      if (!w_send || (r_state != w_next)) begin
        r_phase <= TX_PRESENT;
        r_idx   <= '0;
      end else begin
        case (r_phase)
          TX_PRESENT: r_phase <= TX_RISE;
          TX_RISE:    if (is_transmitting) r_phase <= TX_FALL;
          TX_FALL:    if (!is_transmitting) begin
                        if (!w_last) begin
                          r_idx   <= r_idx + 3'd1;
                          r_phase <= TX_PRESENT;
                        end
`ifdef DIV_CLIENT_ECHO_CHECK_EN
                        else r_phase <= TX_ECHO;
`endif
                      end
          default:    r_phase <= r_phase;
        endcase
      end

      if (r_state == WAIT_X) r_hexcnt <= '0;
      else if ((r_state == HEX) && received && w_hex[4]) begin
        r_shift  <= {r_shift[11:0], w_hex[3:0]};
        r_hexcnt <= r_hexcnt + 2'd1;
      end
      if ((r_state == WAIT_DOT) && (w_next == FIN)) r_result <= r_shift;
    end
  end

`ifdef DIV_CLIENT_ECHO_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_echo_idx <= '0;
    else if (!w_send || (r_state != w_next)) r_echo_idx <= '0;
    else if (received && (r_echo_idx < w_len)) r_echo_idx <= r_echo_idx + 3'd1;
  end
`endif

endmodule

// File: tb/tb_div_query_client.sv
// Directed bench for div_query_client with a loopback UART model that echoes
// each transmitted byte; TIMEOUT_CYCLES shortened to 1000.
module tb_div_query_client;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        busy, done, err, transmit;
  logic [15:0] result;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic [7:0]  rx_byte;
  logic        received;

  logic        m_rcv, e_rcv;
  logic [7:0]  m_byte, e_byte;
  logic        corrupt;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  tx_log[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [15:0] done_res;
  logic        err_busy;

  assign received = m_rcv | e_rcv;
  assign rx_byte  = e_rcv ? e_byte : m_byte;

  always #5 clk = ~clk;

  div_query_client #(.TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .err(err), .result(result),
    .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
    .rx_byte(rx_byte), .received(received)
  );

  // UART model: busy for a few cycles per byte, then echoes it back
  initial begin
    is_transmitting = 1'b0;
    e_rcv  = 1'b0;
    e_byte = 8'h00;
    forever begin
      @(negedge clk);
      e_rcv = 1'b0;
      if (transmit) begin
        tx_log.push_back(tx_byte);
        e_byte = (corrupt && tx_byte == 8'h33) ? 8'h32 : tx_byte;
        @(negedge clk) is_transmitting = 1'b1;
        repeat (3) @(negedge clk);
        is_transmitting = 1'b0;
        e_rcv = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin done_cnt++; done_res = result; end
      if (err)  begin err_cnt++;  err_busy = busy;   end
    end
  end

  function automatic string hex_since(input int base);
    string s = "";
    for (int i = base; i < tx_log.size(); i++) s = $sformatf("%s%02h", s, tx_log[i]);
    return s;
  endfunction

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      m_rcv  = 1'b1;
      m_byte = s[i];
    end
    @(negedge clk) m_rcv = 1'b0;
  endtask

  task automatic wait_cr(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (tx_log.size() > base) && (tx_log[tx_log.size()-1] == 8'h0D);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic kick(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(negedge clk);
  endtask

  // full exchange up to (not including) the reply; ok=0 if a send stalls
  task automatic run_sends(input logic [15:0] a, input logic [15:0] b, output bit ok);
    bit ok1, ok2;
    int base;
    kick(a, b);
    base = tx_log.size();
    send_str("a: ");
    wait_cr(base, ok1);
    base = tx_log.size();
    send_str(": ");
    wait_cr(base, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; m_rcv = 1'b0; m_byte = '0; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (err !== 1'b0)       begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    tests++; if (transmit !== 1'b0)  begin fails++; $display("FAIL reset_transmit got=%b exp=0", transmit); end
    tests++; if (tx_byte !== 8'h00)  begin fails++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    tests++; if (result !== 16'h0)   begin fails++; $display("FAIL reset_result got=%h exp=0000", result); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int base = tx_log.size(), d0 = done_cnt, e0 = err_cnt;
    bit ok;
    string h;
    run_sends(16'd100, 16'd7, ok);
    send_str("0x000E.\r\n");
    repeat (5) @(negedge clk);
    h = hex_since(base);
    tests++; if (!ok)                  begin fails++; $display("FAIL basic_send_stall got=0 exp=1"); end
    tests++; if (h != "3130300d370d")  begin fails++; $display("FAIL basic_tx got=%s exp=3130300d370d", h); end
    tests++; if (done_cnt - d0 != 1)   begin fails++; $display("FAIL basic_done got=%0d exp=1", done_cnt - d0); end
    tests++; if (done_res !== 16'h000E) begin fails++; $display("FAIL basic_result got=%h exp=000e", done_res); end
    tests++; if (err_cnt != e0 || busy !== 1'b0) begin fails++; $display("FAIL basic_idle err=%0d busy=%b exp 0/0", err_cnt - e0, busy); end
  endtask

  task automatic test_zero_max;
    int base = tx_log.size(), d0 = done_cnt;
    bit ok;
    string h;
    run_sends(16'd0, 16'd65535, ok);
    send_str("0x0000.");
    repeat (5) @(negedge clk);
    h = hex_since(base);
    tests++; if (!ok || h != "300d36353533350d") begin fails++; $display("FAIL zmax_tx got=%s exp=300d36353533350d", h); end
    tests++; if (done_cnt - d0 != 1)    begin fails++; $display("FAIL zmax_done got=%0d exp=1", done_cnt - d0); end
    tests++; if (result !== 16'h0000)   begin fails++; $display("FAIL zmax_result got=%h exp=0000", result); end
  endtask

  task automatic test_hex_case;
    int base = tx_log.size(), d0 = done_cnt;
    bit ok;
    string h;
    run_sends(16'd48879, 16'd1, ok);
    send_str("00xbEeF.");
    repeat (5) @(negedge clk);
    h = hex_since(base);
    tests++; if (!ok || h != "34383837390d310d") begin fails++; $display("FAIL hex_tx got=%s exp=34383837390d310d", h); end
    tests++; if (done_cnt - d0 != 1 || done_res !== 16'hBEEF) begin fails++; $display("FAIL hex_result got=%h n=%0d exp=beef n=1", done_res, done_cnt - d0); end
  endtask

  task automatic test_bad_hex;
    int d0 = done_cnt, e0 = err_cnt;
    bit ok;
    run_sends(16'd9, 16'd3, ok);
    send_str("0x00G1.");
    repeat (5) @(negedge clk);
    tests++; if (err_cnt - e0 != 1)  begin fails++; $display("FAIL badhex_err got=%0d exp=1", err_cnt - e0); end
    tests++; if (done_cnt != d0)     begin fails++; $display("FAIL badhex_done got=%0d exp=0", done_cnt - d0); end
    tests++; if (err_busy !== 1'b0)  begin fails++; $display("FAIL badhex_busy got=%b exp=0", err_busy); end
  endtask

  task automatic test_timeout;
    int e0 = err_cnt, n = 0;
    @(negedge clk);
    op_a = 16'd5; op_b = 16'd2; start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (err_cnt == e0 && n < 3000) begin @(negedge clk); n++; end
    tests++; if (err_cnt - e0 != 1)       begin fails++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e0); end
    tests++; if (n < 1000 || n > 1100)    begin fails++; $display("FAIL timeout_latency got=%0d exp=1000..1100", n); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int base, n = 0;
    kick(16'd12345, 16'd5);
    base = tx_log.size();
    send_str(": ");
    while (tx_log.size() < base + 3 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (tx_log.size() < base + 3) begin fails++; $display("FAIL rstmid_third_byte got=%0d exp=3", tx_log.size() - base); end
    tests++; if (transmit !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_outputs transmit=%b busy=%b exp 0/0", transmit, busy); end
    tests++; if (result !== 16'h0000) begin fails++; $display("FAIL rstmid_result got=%h exp=0000", result); end
    @(negedge clk);
    rst = 1'b0; op_a = 16'd1; op_b = 16'd1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_restart busy=%b exp=1", busy); end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_echo;
    int d0 = done_cnt, e0 = err_cnt, base;
    bit ok1, ok2;
    corrupt = 1'b1;
    kick(16'd13, 16'd1);
    base = tx_log.size();
    send_str(": ");
`ifdef DIV_CLIENT_ECHO_CHECK_EN
    repeat (40) @(negedge clk);
    tests++; if (err_cnt - e0 != 1)  begin fails++; $display("FAIL echo_err got=%0d exp=1", err_cnt - e0); end
    tests++; if (done_cnt != d0 || busy !== 1'b0) begin fails++; $display("FAIL echo_abort done=%0d busy=%b exp 0/0", done_cnt - d0, busy); end
`else
    wait_cr(base, ok1);
    base = tx_log.size();
    send_str(": ");
    wait_cr(base, ok2);
    send_str("0x000D.");
    repeat (5) @(negedge clk);
    tests++; if (!ok1 || !ok2 || err_cnt != e0) begin fails++; $display("FAIL echo_ignored err=%0d exp=0", err_cnt - e0); end
    tests++; if (done_cnt - d0 != 1 || done_res !== 16'h000D) begin fails++; $display("FAIL echo_done got=%h n=%0d exp=000d n=1", done_res, done_cnt - d0); end
`endif
    corrupt = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_max;
    test_hex_case;
    test_bad_hex;
    test_timeout;
    test_reset_mid;
    test_echo;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
